// File: rtl/fetch_unit.sv
// Instruction fetch stage: sync program-memory reads into a DEPTH-entry FIFO presented to decode.
// Optional macro FETCH_PERF_EN adds saturating handshake and stall counters.
module fetch_unit #(
    parameter int              PC_W      = 32,
    parameter int              I_W       = 32,
    parameter int              DEPTH     = 4,
    parameter int              MAX_INSTR = 10,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                enable_in,
    input  logic                redirect_in,
    input  logic [PC_W-1:0]     redirect_pc_in,
    output logic                imem_rd_out,
    output logic [PC_W-3:0]     imem_addr_out,
    input  logic [I_W-1:0]      imem_data_in,
    output logic [I_W+PC_W-1:0] data_out,
    output logic                valid_out,
    input  logic                rdy_in,
    output logic                done_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         fetched_cnt_out,
    output logic [31:0]         stall_cnt_out
`endif
);
    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_V = (CNT_W+1)'(DEPTH);
    localparam logic [PC_W-3:0]   MAX_IDX = (PC_W-2)'(MAX_INSTR);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL, S_END} state_t;

    state_t                r_state, w_state_nxt;
    logic [PC_W-1:0]       r_pc;
    logic [PC_W-1:0]       r_tag_pc;
    logic                  r_inflight;
    logic [I_W+PC_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wptr, r_rptr;
    logic [CNT_W-1:0]      r_count;

    logic [PC_W-3:0]       w_pc_idx, w_pc_nxt_idx;
    logic [CNT_W:0]        w_used, w_used_nxt;
    logic                  w_credit, w_issue, w_push, w_pop;

    assign w_pc_idx     = r_pc[PC_W-1:2];
    assign w_used       = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
    assign w_credit     = w_used < DEPTH_V;
    assign w_issue      = (r_state == S_FETCH) && enable_in && !redirect_in &&
                          w_credit && (w_pc_idx < MAX_IDX);
    assign w_push       = r_inflight;
    assign w_pop        = valid_out && rdy_in;
    assign w_pc_nxt_idx = w_pc_idx + (PC_W-2)'(w_issue);
    // Occupancy after this edge, so the last credit spent moves straight to S_FULL.
    assign w_used_nxt   = w_used + (CNT_W+1)'(w_issue) - (CNT_W+1)'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (enable_in) w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (!enable_in)                   w_state_nxt = S_IDLE;
                else if (w_pc_nxt_idx >= MAX_IDX) w_state_nxt = S_END;
                else if (w_used_nxt >= DEPTH_V)   w_state_nxt = S_FULL;
            end
            S_FULL: begin
                if (!enable_in)    w_state_nxt = S_IDLE;
                else if (w_credit) w_state_nxt = S_FETCH;
            end
            S_END:   w_state_nxt = S_END;
        endcase
        if (redirect_in) w_state_nxt = enable_in ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_tag_pc   <= '0;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_in) begin
                r_pc       <= redirect_pc_in;
                r_inflight <= 1'b0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_count    <= '0;
            end else begin
                if (w_issue) begin
                    r_pc     <= r_pc + PC_W'(4);
                    r_tag_pc <= r_pc;
                end
                r_inflight <= w_issue;
                if (w_push) r_wptr <= r_wptr + PTR_W'(1);
                if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // NOTE: FIFO storage has no reset; data_out is masked while empty, so stale entries never show.
    always_ff @(posedge clk_in) begin
        if (w_push && !redirect_in) r_mem[r_wptr] <= {imem_data_in, r_tag_pc};
    end

    assign imem_rd_out   = w_issue;
    assign imem_addr_out = w_issue ? w_pc_idx : '0;
    assign valid_out     = (r_count != '0);
    assign data_out      = valid_out ? r_mem[r_rptr] : '0;
    assign done_out      = (r_state == S_END) && (r_count == '0) && !r_inflight;

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetched_cnt, r_stall_cnt;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_fetched_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            if (w_pop && (r_fetched_cnt != '1))               r_fetched_cnt <= r_fetched_cnt + 32'd1;
            if ((r_state == S_FULL) && (r_stall_cnt != '1))   r_stall_cnt   <= r_stall_cnt + 32'd1;
        end
    end

    assign fetched_cnt_out = r_fetched_cnt;
    assign stall_cnt_out   = r_stall_cnt;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: program-order reference model plus directed and random scenarios.
module tb_fetch_unit;
    localparam int PC_W = 32, I_W = 32, DEPTH = 4, MAX_INSTR = 10;

    logic               clk_in = 1'b0;
    logic               reset_in = 1'b1;
    logic               enable_in = 1'b0, redirect_in = 1'b0, rdy_in = 1'b0;
    logic [PC_W-1:0]    redirect_pc_in = '0;
    logic               imem_rd_out;
    logic [PC_W-3:0]    imem_addr_out;
    logic [I_W-1:0]     imem_data_in = '0;
    logic [I_W+PC_W-1:0] data_out;
    logic               valid_out, done_out;
`ifdef FETCH_PERF_EN
    logic [31:0]        fetched_cnt_out, stall_cnt_out;
`endif

    fetch_unit #(.PC_W(PC_W), .I_W(I_W), .DEPTH(DEPTH), .MAX_INSTR(MAX_INSTR)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in),
        .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
        .imem_rd_out(imem_rd_out), .imem_addr_out(imem_addr_out), .imem_data_in(imem_data_in),
        .data_out(data_out), .valid_out(valid_out), .rdy_in(rdy_in), .done_out(done_out)
`ifdef FETCH_PERF_EN
        , .fetched_cnt_out(fetched_cnt_out), .stall_cnt_out(stall_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks = 0, errors = 0;
    int rd_cnt = 0, hs_cnt = 0;
    logic [31:0] mem [64];

    // Synchronous program memory: one-cycle read latency, never reset.
    always @(posedge clk_in) begin
        if (imem_rd_out) imem_data_in <= mem[imem_addr_out[5:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: decode must see {mem[pc/4], pc} in program order from the last reset/redirect.
    logic [31:0] exp_pc = 32'h0;
    logic        prev_hold = 1'b0, prev_redirect = 1'b0;
    logic [63:0] prev_data = '0;

    always @(negedge clk_in) begin
        if (!reset_in) begin
            exp_pc        = 32'h0;
            prev_hold     = 1'b0;
            prev_redirect = 1'b0;
            check("reset_data", data_out, 64'h0);
            check("reset_ctrl", {imem_rd_out, valid_out, done_out, imem_addr_out}, '0);
        end else begin
            if (prev_redirect) check("valid_after_redirect", valid_out, 0);
            if (prev_hold) begin
                check("hold_valid", valid_out, 1);
                check("hold_data", data_out, prev_data);
            end
            if (imem_rd_out) begin
                rd_cnt++;
                check("rd_addr_in_range", imem_addr_out < MAX_INSTR, 1);
            end
            if (redirect_in) check("rd_suppressed_on_redirect", imem_rd_out, 0);
            if (done_out) begin
                check("done_all_delivered", exp_pc[31:2] >= MAX_INSTR, 1);
                check("done_not_valid", valid_out, 0);
            end
            if (valid_out && rdy_in) begin
                check("xfer_in_range", exp_pc[31:2] < MAX_INSTR, 1);
                check("xfer", data_out, {mem[exp_pc[7:2]], exp_pc});
                exp_pc = exp_pc + 32'd4;
                hs_cnt++;
            end
            prev_hold     = valid_out && !rdy_in && !redirect_in;
            prev_data     = data_out;
            prev_redirect = redirect_in;
            if (redirect_in) exp_pc = redirect_pc_in;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        enable_in = 1'b0; redirect_in = 1'b0; rdy_in = 1'b0; redirect_pc_in = '0;
        reset_in = 1'b0;
        tick(); tick();
        reset_in = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !done_out; i++) tick();
        check(name, done_out, 1);
    endtask

    initial begin
        int hs0, rd0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h13 + i;

        // Straight-line run: latency and full delivery.
        do_reset();
        hs0 = hs_cnt;
        rdy_in = 1'b1; enable_in = 1'b1;
        tick(); check("lat_c1", valid_out, 0);
        tick(); check("lat_c2", valid_out, 0);
        tick(); check("lat_c3", valid_out, 1);
        check("first_data", data_out, {32'h13, 32'h0});
        wait_done("s1_done", 100);
        check("s1_count", hs_cnt - hs0, 10);
        check("s1_model_end_pc", exp_pc, 32'h28);

        // Backpressure: credit limits reads to DEPTH.
        do_reset();
        hs0 = hs_cnt; rd0 = rd_cnt;
        enable_in = 1'b1;
        repeat (20) tick();
        check("s2_reads", rd_cnt - rd0, DEPTH);
        check("s2_head", data_out, {32'h13, 32'h0});
        rdy_in = 1'b1;
        wait_done("s2_done", 100);
        check("s2_count", hs_cnt - hs0, 10);
`ifdef FETCH_PERF_EN
        check("s2_stall_cnt", stall_cnt_out, 17);
        check("s2_fetched_cnt", fetched_cnt_out, 10);
`endif

        // Redirect with a full-ish FIFO and a read in flight.
        do_reset();
        enable_in = 1'b1;
        repeat (5) tick();
        redirect_in = 1'b1; redirect_pc_in = 32'h10;
        tick();
        redirect_in = 1'b0;
        hs0 = hs_cnt;
        check("s3_flushed", valid_out, 0);
        tick(); tick();
        check("s3_first_valid", valid_out, 1);
        check("s3_first_data", data_out, {32'h17, 32'h10});
        rdy_in = 1'b1;
        wait_done("s3_done", 100);
        check("s3_count", hs_cnt - hs0, 6);

        // rdy toggling every cycle.
        do_reset();
        hs0 = hs_cnt;
        enable_in = 1'b1;
        for (int i = 0; i < 200 && !done_out; i++) begin
            rdy_in = ~rdy_in;
            tick();
        end
        check("s4_done", done_out, 1);
        check("s4_count", hs_cnt - hs0, 10);

        // Mid-stream reset.
        do_reset();
        rdy_in = 1'b1; enable_in = 1'b1;
        for (int i = 0; i < 50 && !(valid_out && data_out[31:0] == 32'h14); i++) tick();
        check("s5_reached_0x14", valid_out && data_out[31:0] == 32'h14, 1);
        reset_in = 1'b0;
        #1;
        check("s5_rst_valid", valid_out, 0);
        check("s5_rst_data", data_out, 64'h0);
        check("s5_rst_ctrl", {imem_rd_out, done_out, imem_addr_out}, '0);
        tick();
        reset_in = 1'b1;
        hs0 = hs_cnt;
        wait_done("s5_done", 100);
        check("s5_count", hs_cnt - hs0, 10);

        // Randomized: enable drops, backpressure and redirects, then drain.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
            for (int c = 0; c < 600; c++) begin
                rdy_in         = ($urandom_range(0, 3) != 0);
                enable_in      = ($urandom_range(0, 15) != 0);
                redirect_in    = ($urandom_range(0, 30) == 0);
                redirect_pc_in = 32'($urandom_range(0, 12)) * 32'd4;
                tick();
            end
            redirect_in = 1'b0; enable_in = 1'b1; rdy_in = 1'b1;
            wait_done("rand_done", 200);
            check("rand_model_exhausted", exp_pc[31:2] >= MAX_INSTR, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
